// File: rtl/ladder_checkpoint_store_if.sv
// Command/status bundle for the ladder checkpoint store.
// Command semantics: every command input (clear, stage_valid, commit, rollback)
// is a level sampled once per rising CLK edge. Each sampled cycle counts as one
// request. There is no ready or back-pressure. dout_valid is a one-cycle
// qualifier for dout/dout_idx, and dout/dout_idx hold between restores.
interface ladder_checkpoint_store_if #(
    parameter int N         = 233,
    parameter int DEPTH     = 2,
    parameter int MAX_RETRY = 3,
    parameter int IDX_W     = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    logic             clear;
    logic             stage_valid;
    logic [6*N-1:0]   din;
    logic [IDX_W-1:0] din_idx;
    logic             commit;
    logic             rollback;
    logic [6*N-1:0]   dout;
    logic [IDX_W-1:0] dout_idx;
    logic             dout_valid;
    logic [CNT_W-1:0] count;
    logic             staged;
    logic [RTY_W-1:0] retry_cnt;
    logic             cmd_err;
    logic             abort;

    modport master (
        output clear, stage_valid, din, din_idx, commit, rollback,
        input  dout, dout_idx, dout_valid, count, staged, retry_cnt, cmd_err, abort
    );

    modport slave (
        input  clear, stage_valid, din, din_idx, commit, rollback,
        output dout, dout_idx, dout_valid, count, staged, retry_cnt, cmd_err, abort
    );
endinterface

// File: rtl/ladder_checkpoint_store.sv
// Checkpoint/rollback store for the fault-protected Montgomery ladder.
// Verified snapshots live in a DEPTH-entry ring. A fault restores the newest
// snapshot. Repeated faults discard it and fall back one level. An empty ring
// raises a sticky abort.
module ladder_checkpoint_store #(
    parameter int N         = 233,
    parameter int DEPTH     = 2,
    parameter int MAX_RETRY = 3,
    parameter int IDX_W     = 8
) (
    input  logic CLK,
    input  logic RST_N,
    ladder_checkpoint_store_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam logic [RTY_W-1:0] RTY_ONE  = RTY_W'(1);

    logic [6*N-1:0]   ring_data [DEPTH];
    logic [IDX_W-1:0] ring_idx  [DEPTH];
    logic [6*N-1:0]   stage_data;
    logic [IDX_W-1:0] stage_idx;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] newest_ptr;
    logic [PTR_W-1:0] older_ptr;
    logic [CNT_W-1:0] count;
    logic [RTY_W-1:0] retry_cnt;
    logic             staged;
    logic             abort;
    logic             dout_valid;
    logic             cmd_err;
    logic [6*N-1:0]   dout;
    logic [IDX_W-1:0] dout_idx;

    logic             do_commit;
    logic             do_stage;

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == '0) ? PTR_LAST : p - 1'b1;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // Ring addressing and qualified write strobes for the data path.
    always_comb begin
        newest_ptr = ptr_dec(wr_ptr);
        older_ptr  = ptr_dec(newest_ptr);
        do_commit  = !bus.clear && !abort && !bus.rollback && bus.commit && staged;
        do_stage   = !bus.clear && !abort && !bus.rollback && bus.stage_valid;
    end

    // Ring and staging storage; contents are meaningless until written, so no reset.
    always_ff @(posedge CLK) begin
        if (do_commit) begin
            ring_data[wr_ptr] <= stage_data;
            ring_idx[wr_ptr]  <= stage_idx;
        end
        if (do_stage) begin
            stage_data <= bus.din;
            stage_idx  <= bus.din_idx;
        end
    end

    // Control: command priority clear > rollback > commit > stage_valid; abort freezes all but clear.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            count      <= '0;
            retry_cnt  <= '0;
            staged     <= 1'b0;
            abort      <= 1'b0;
            dout_valid <= 1'b0;
            cmd_err    <= 1'b0;
            dout       <= '0;
            dout_idx   <= '0;
        end else begin
            dout_valid <= 1'b0;
            cmd_err    <= 1'b0;
            if (bus.clear) begin
                wr_ptr    <= '0;
                count     <= '0;
                retry_cnt <= '0;
                staged    <= 1'b0;
                abort     <= 1'b0;
            end else if (!abort) begin
                if (bus.rollback) begin
                    staged  <= 1'b0;
                    cmd_err <= bus.commit;
                    if (count == '0) begin
                        abort <= 1'b1;
                    end else if (retry_cnt != RTY_MAX) begin
                        dout       <= ring_data[newest_ptr];
                        dout_idx   <= ring_idx[newest_ptr];
                        dout_valid <= 1'b1;
                        retry_cnt  <= retry_cnt + 1'b1;
                    end else if (count != CNT_ONE) begin
                        // Newest snapshot keeps failing: drop it and retry the one below.
                        count      <= count - 1'b1;
                        wr_ptr     <= newest_ptr;
                        dout       <= ring_data[older_ptr];
                        dout_idx   <= ring_idx[older_ptr];
                        dout_valid <= 1'b1;
                        retry_cnt  <= RTY_ONE;
                    end else begin
                        count     <= '0;
                        wr_ptr    <= newest_ptr;
                        retry_cnt <= '0;
                        abort     <= 1'b1;
                    end
                end else begin
                    if (bus.commit) begin
                        if (staged) begin
                            wr_ptr    <= ptr_inc(wr_ptr);
                            retry_cnt <= '0;
                            staged    <= 1'b0;
                            if (count != CNT_FULL) begin
                                count <= count + 1'b1;
                            end
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                    if (bus.stage_valid) begin
                        staged <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.dout       = dout;
    assign bus.dout_idx   = dout_idx;
    assign bus.dout_valid = dout_valid;
    assign bus.count      = count;
    assign bus.staged     = staged;
    assign bus.retry_cnt  = retry_cnt;
    assign bus.cmd_err    = cmd_err;
    assign bus.abort      = abort;
endmodule

// File: tb/tb_ladder_checkpoint_store.sv
// Directed bench for ladder_checkpoint_store with N=8, DEPTH=2, MAX_RETRY=2, IDX_W=8.
module tb_ladder_checkpoint_store;
    localparam int N         = 8;
    localparam int DEPTH     = 2;
    localparam int MAX_RETRY = 2;
    localparam int IDX_W     = 8;

    localparam logic [47:0] SNAP_BASIC = 48'h010203040506;
    localparam logic [47:0] SNAP_A     = 48'hA1A2A3A4A5A6;
    localparam logic [47:0] SNAP_B     = 48'hB1B2B3B4B5B6;
    localparam logic [47:0] SNAP_C     = 48'hC1C2C3C4C5C6;
    localparam logic [47:0] SNAP_D     = 48'hD1D2D3D4D5D6;
    localparam logic [47:0] SNAP_E     = 48'hE1E2E3E4E5E6;
    localparam logic [47:0] SNAP_F     = 48'hF1F2F3F4F5F6;
    localparam logic [47:0] SNAP_G     = 48'h123456789ABC;
    localparam logic [47:0] SNAP_H     = 48'h0F0E0D0C0B0A;

    logic CLK;
    logic RST_N;
    int   n_checks;
    int   n_errors;

    ladder_checkpoint_store_if #(
        .N(N), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .IDX_W(IDX_W)
    ) bus ();

    ladder_checkpoint_store #(
        .N(N), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .IDX_W(IDX_W)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    // Clock and reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input int cnt, input int stg, input int rty,
                                input int vld, input int err, input int abt);
        check_eq({tag, ".count"},      64'(bus.count),      64'(cnt));
        check_eq({tag, ".staged"},     64'(bus.staged),     64'(stg));
        check_eq({tag, ".retry_cnt"},  64'(bus.retry_cnt),  64'(rty));
        check_eq({tag, ".dout_valid"}, 64'(bus.dout_valid), 64'(vld));
        check_eq({tag, ".cmd_err"},    64'(bus.cmd_err),    64'(err));
        check_eq({tag, ".abort"},      64'(bus.abort),      64'(abt));
    endtask

    task automatic check_restore(input string tag, input logic [47:0] d, input int idx);
        check_eq({tag, ".dout"},     64'(bus.dout),     64'(d));
        check_eq({tag, ".dout_idx"}, 64'(bus.dout_idx), 64'(idx));
    endtask

    // Driver: apply one cycle of commands, then return all commands to idle
    // 1 time unit after the edge, so outputs of that edge are readable.
    task automatic drive(input logic c, input logic sv, input logic cm, input logic rb,
                         input logic [47:0] d, input logic [7:0] idx);
        bus.clear       = c;
        bus.stage_valid = sv;
        bus.commit      = cm;
        bus.rollback    = rb;
        bus.din         = d;
        bus.din_idx     = idx;
        @(posedge CLK);
        #1;
        bus.clear       = 1'b0;
        bus.stage_valid = 1'b0;
        bus.commit      = 1'b0;
        bus.rollback    = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask
    task automatic do_clear();
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask
    task automatic do_stage(input logic [47:0] d, input logic [7:0] idx);
        drive(1'b0, 1'b1, 1'b0, 1'b0, d, idx);
    endtask
    task automatic do_commit();
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
    endtask
    task automatic do_rollback();
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0, '0);
    endtask
    task automatic do_reset();
        RST_N = 1'b0;
        idle();
        RST_N = 1'b1;
    endtask

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        RST_N           = 1'b0;
        bus.clear       = 1'b0;
        bus.stage_valid = 1'b0;
        bus.commit      = 1'b0;
        bus.rollback    = 1'b0;
        bus.din         = '0;
        bus.din_idx     = '0;
        idle();
        idle();
        check_status("reset", 0, 0, 0, 0, 0, 0);
        check_restore("reset", '0, 0);
        RST_N = 1'b1;

        // Basic restore
        do_stage(SNAP_BASIC, 8'd5);
        check_status("basic_stage", 0, 1, 0, 0, 0, 0);
        do_commit();
        check_status("basic_commit", 1, 0, 0, 0, 0, 0);
        do_rollback();
        check_status("basic_rb", 1, 0, 1, 1, 0, 0);
        check_restore("basic_rb", SNAP_BASIC, 5);
        idle();
        check_status("basic_after", 1, 0, 1, 0, 0, 0);
        check_restore("basic_hold", SNAP_BASIC, 5);

        // Ring overwrite, discard and exhaustion
        do_clear();
        check_status("clear", 0, 0, 0, 0, 0, 0);
        check_restore("clear_keeps_dout", SNAP_BASIC, 5);
        do_stage(SNAP_A, 8'd1);
        do_commit();
        do_stage(SNAP_B, 8'd2);
        do_commit();
        do_stage(SNAP_C, 8'd3);
        do_commit();
        check_status("ring_full", 2, 0, 0, 0, 0, 0);
        do_rollback();
        check_status("ring_rb1", 2, 0, 1, 1, 0, 0);
        check_restore("ring_rb1", SNAP_C, 3);
        do_rollback();
        check_status("ring_rb2", 2, 0, 2, 1, 0, 0);
        check_restore("ring_rb2", SNAP_C, 3);
        do_rollback();
        check_status("ring_discard", 1, 0, 1, 1, 0, 0);
        check_restore("ring_discard", SNAP_B, 2);
        do_rollback();
        check_status("ring_rb4", 1, 0, 2, 1, 0, 0);
        check_restore("ring_rb4", SNAP_B, 2);
        do_rollback();
        check_eq("ring_exhaust.count",      64'(bus.count),      64'd0);
        check_eq("ring_exhaust.abort",      64'(bus.abort),      64'd1);
        check_eq("ring_exhaust.dout_valid", 64'(bus.dout_valid), 64'd0);
        check_restore("ring_exhaust_hold", SNAP_B, 2);

        // Empty rollback after reset, then commands ignored while aborted
        do_reset();
        check_status("reset2", 0, 0, 0, 0, 0, 0);
        do_rollback();
        check_status("empty_rb", 0, 0, 0, 0, 0, 1);
        do_stage(SNAP_A, 8'd1);
        check_status("abort_stage", 0, 0, 0, 0, 0, 1);
        do_commit();
        check_status("abort_commit", 0, 0, 0, 0, 0, 1);
        do_rollback();
        check_status("abort_rb", 0, 0, 0, 0, 0, 1);
        do_clear();
        check_status("abort_clear", 0, 0, 0, 0, 0, 0);

        // Illegal and simultaneous commands
        do_commit();
        check_status("commit_empty", 0, 0, 0, 0, 1, 0);
        idle();
        check_status("commit_empty_after", 0, 0, 0, 0, 0, 0);
        do_stage(SNAP_D, 8'd7);
        do_commit();
        check_status("commit_d", 1, 0, 0, 0, 0, 0);
        do_stage(SNAP_E, 8'd8);
        check_status("stage_e", 1, 1, 0, 0, 0, 0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        check_status("commit_rb", 1, 0, 1, 1, 1, 0);
        check_restore("commit_rb", SNAP_D, 7);

        // Retry counter clears on progress; commit+stage keeps staged
        do_stage(SNAP_F, 8'd9);
        drive(1'b0, 1'b1, 1'b1, 1'b0, SNAP_G, 8'd10);
        check_status("commit_stage", 2, 1, 0, 0, 0, 0);
        do_rollback();
        check_status("progress_rb", 2, 0, 1, 1, 0, 0);
        check_restore("progress_rb", SNAP_F, 9);

        // Reset mid-operation overrides concurrent commands
        do_stage(SNAP_H, 8'd11);
        check_status("pre_reset", 2, 1, 1, 0, 0, 0);
        RST_N = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        RST_N = 1'b1;
        check_status("mid_reset", 0, 0, 0, 0, 0, 0);
        check_restore("mid_reset", '0, 0);
        do_rollback();
        check_status("post_reset_rb", 0, 0, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
